mult_result_bcd: RTL and testbench



---
 rtl/mult_pkg.sv | 19 +
 rtl/bcd_add3_stage.sv | 15 +
 rtl/mult_result_bcd.sv | 133 +++++++++++++
 tb/tb_mult_result_bcd.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier result path.
// Also holds the BCD digit correction used by the double-dabble converter.
package mult_pkg;

  localparam int RES_W      = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Pre-shift correction: a digit of 5 or more would overflow past 9 when doubled.
  function automatic logic [3:0] add3_correct(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational add-3 correction applied to every packed BCD nibble in parallel.
module bcd_add3_stage
  import mult_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] dout
);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign dout[4*gi +: 4] = add3_correct(din[4*gi +: 4]);
  end

endmodule

// File: rtl/mult_result_bcd.sv
// Captures the multiplier magnitude/sign and converts it to packed BCD,
// one bit per clock, with a leading-zero blank mask for the display driver.
module mult_result_bcd
  import mult_pkg::*;
#(
  parameter int WIDTH  = RES_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  input  logic                sign_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                sign_out,
  output logic [DIGITS-1:0]   blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  // DIGITS >= ceil(WIDTH * log10(2)), evaluated in fixed point.
  if (DIGITS * 100000 < WIDTH * 30103) begin : g_bad_digits
    $error("mult_result_bcd: DIGITS too small for WIDTH");
  end

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   sr_reg, sr_next;
  logic [BCD_W-1:0]   scratch_reg, scratch_next;
  logic               sign_lat_reg, sign_lat_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [BCD_W-1:0]   bcd_reg, bcd_next;
  logic               sign_out_reg, sign_out_next;
  logic [DIGITS-1:0]  blank_reg, blank_next;

  logic [BCD_W-1:0]   scratch_adj;
  logic [DIGITS-1:0]  blank_calc;

  bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
    .din  (scratch_reg),
    .dout (scratch_adj)
  );

  // A digit blanks only when it and every more significant digit are zero.
  assign blank_calc[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
    assign blank_calc[gi] = ~|scratch_reg[BCD_W-1:4*gi];
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sr_next       = sr_reg;
    scratch_next  = scratch_reg;
    sign_lat_next = sign_lat_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    bcd_next      = bcd_reg;
    sign_out_next = sign_out_reg;
    blank_next    = blank_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          sr_next       = bin_in;
          scratch_next  = '0;
          sign_lat_next = sign_in;
          cnt_next      = '0;
          busy_next     = 1'b1;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_next = {scratch_adj[BCD_W-2:0], sr_reg[WIDTH-1]};
        sr_next      = {sr_reg[WIDTH-2:0], 1'b0};
        cnt_next     = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        bcd_next      = scratch_reg;
        blank_next    = blank_calc;
        // Zero magnitude never shows a minus sign.
        sign_out_next = sign_lat_reg & (|scratch_reg);
        done_next     = 1'b1;
        busy_next     = 1'b0;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sr_reg       <= '0;
      scratch_reg  <= '0;
      sign_lat_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      sign_out_reg <= 1'b0;
      blank_reg    <= BLANK_RST;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sr_reg       <= sr_next;
      scratch_reg  <= scratch_next;
      sign_lat_reg <= sign_lat_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      bcd_reg      <= bcd_next;
      sign_out_reg <= sign_out_next;
      blank_reg    <= blank_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign bcd_out  = bcd_reg;
  assign sign_out = sign_out_reg;
  assign blank    = blank_reg;

endmodule

// File: tb/tb_mult_result_bcd.sv
// Scoreboard bench for mult_result_bcd: expected results are queued at issue
// time from a decimal-arithmetic model and checked whenever done pulses.
module tb_mult_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin_in = '0;
  logic        sign_in = 1'b0;
  logic        busy, done, sign_out;
  logic [19:0] bcd_out;
  logic [4:0]  blank;

  typedef struct packed {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        sign;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;
  int   dones  = 0;

  mult_result_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .sign_in  (sign_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .sign_out (sign_out),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, blanking from the value itself.
  function automatic exp_t model(input int unsigned v, input bit s);
    exp_t e;
    int unsigned p;
    e.bcd   = '0;
    e.blank = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'((v / p) % 10);
      if (i > 0) e.blank[i] = ((v / p) == 0);
      p = p * 10;
    end
    e.sign = s && (v != 0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("blank", 32'(blank), 32'(e.blank));
        chk("sign_out", 32'(sign_out), 32'(e.sign));
        $display("result bcd=%05h blank=%05b sign=%0b (exp %05h %05b %0b)",
                 bcd_out, blank, sign_out, e.bcd, e.blank, e.sign);
      end
    end
  end

  // Called at #1 after an edge; the next edge is the accepting edge E0.
  task automatic issue(input int unsigned v, input bit s, input bit expect_result);
    if (expect_result) begin
      sb.push_back(model(v, s));
      issued++;
    end
    start   = 1'b1;
    bin_in  = 16'(v);
    sign_in = s;
    @(posedge clk);
    #1;
    start   = 1'b0;
    bin_in  = 16'($urandom);
    sign_in = 1'($urandom);
  endtask

  // Counts edges after E0 until done; optionally pulses a start at edge inject_k.
  task automatic wait_done(input int inject_k);
    int  k;
    bit  busy_ok;
    k = 0;
    busy_ok = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == inject_k) begin
        start  = 1'b1;
        bin_in = 16'd999;
      end
      if (k >= 40) begin
        chk("done_timeout", 32'(k), 32'd17);
        return;
      end
    end
    chk("latency", 32'(k), 32'd17);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_blank", 32'(blank), 32'b11110);
    chk("rst_sign", 32'(sign_out), 32'd0);
    rst = 1'b0;
    idle(2);

    issue(12, 0, 1);      wait_done(0); idle(2);
    issue(65535, 1, 1);   wait_done(0); idle(2);
    issue(0, 1, 1);       wait_done(0); idle(2);

    // Start while busy is dropped.
    issue(30, 0, 1);      wait_done(5); idle(20);

    // Reset mid-conversion discards the operand.
    issue(4321, 0, 0);
    idle(7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_blank", 32'(blank), 32'b11110);
    chk("midrst_sign", 32'(sign_out), 32'd0);
    idle(20);
    issue(30, 0, 1);      wait_done(0); idle(2);

    // Back-to-back: start held during the done cycle.
    issue(12, 0, 1);      wait_done(0);
    issue(30, 1, 1);      wait_done(0);

    // Randomized operands, with random gaps including zero.
    for (int i = 0; i < 24; i++) begin
      int unsigned v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        default: v = $urandom_range(0, 65535);
      endcase
      issue(v, 1'($urandom), 1);
      wait_done(0);
      idle($urandom_range(0, 3));
    end

    idle(25);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
